// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and frame error pulse
//
// Ports:
//   sclk      - system clock, all state changes on its rising edge
//   s_rst_n   - asynchronous active-low reset
//   rs232_rx  - asynchronous serial line, idle high, 1 start / 8 data LSB first / 1 stop
//   po_data   - last correctly received byte, held between po_flag pulses
//   po_flag   - one-cycle pulse, po_data valid in the same cycle
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   rx_busy   - high while a frame is being received

module uart_rx #(
    parameter int BAUD_END = 5207,
    parameter int BAUD_M   = BAUD_END / 2 - 1
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       rs232_rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(BAUD_END + 1);
    localparam logic [CW-1:0] BAUD_END_C = CW'(BAUD_END);
    localparam logic [CW-1:0] BAUD_M_C   = CW'(BAUD_M);

    logic          rx_r1;
    logic          rx_r2;
    logic          rx_r3;
    logic          rx_flag;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          start_edge;
    logic          sample_pt;

    // Falling edge seen between the last two synchronizer stages while idle.
    assign start_edge = rx_r3 & ~rx_r2 & ~rx_flag;
    assign sample_pt  = rx_flag && (baud_cnt == BAUD_M_C);
    assign rx_busy    = rx_flag;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rx_r1     <= 1'b1;
            rx_r2     <= 1'b1;
            rx_r3     <= 1'b1;
            rx_flag   <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            po_data   <= 8'h00;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_r1     <= rs232_rx;
            rx_r2     <= rx_r1;
            rx_r3     <= rx_r2;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;

            if (start_edge) begin
                rx_flag <= 1'b1;
            end

            if (!rx_flag || baud_cnt == BAUD_END_C) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (sample_pt) begin
                if (bit_cnt == 4'd0) begin
                    // A high start sample means the low was a glitch: drop back to idle.
                    if (rx_r3) begin
                        rx_flag  <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= 4'd0;
                    end else begin
                        bit_cnt <= 4'd1;
                    end
                end else if (bit_cnt == 4'd9) begin
                    // Frame ends at the stop-bit midpoint so the next start edge is never missed.
                    rx_flag  <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= 4'd0;
                    if (rx_r3) begin
                        po_data <= shift_reg;
                        po_flag <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shift_reg <= {rx_r3, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx

module tb_uart_rx;

    localparam int BAUD_END = 56;
    localparam int BAUD_M   = 27;
    localparam int BIT_CYC  = BAUD_END + 1;

    logic       sclk;
    logic       s_rst_n;
    logic       rs232_rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;
    logic       rx_busy;

    int tests;
    int fails;
    int fe_cnt;
    int both_cnt;
    logic [7:0] got_q[$];

    uart_rx #(
        .BAUD_END(BAUD_END),
        .BAUD_M  (BAUD_M)
    ) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .rs232_rx (rs232_rx),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (po_flag) got_q.push_back(po_data);
        if (frame_err) fe_cnt++;
        if (po_flag && frame_err) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    // Caller must be at a falling edge; drives a full frame of exactly 10 bit periods.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rs232_rx = bits[i];
            repeat (BIT_CYC) @(negedge sclk);
        end
        rs232_rx = 1'b1;
    endtask

    task automatic clear_log();
        got_q.delete();
        fe_cnt   = 0;
        both_cnt = 0;
    endtask

    task automatic test_reset();
        s_rst_n  = 1'b0;
        rs232_rx = 1'b1;
        repeat (3) @(negedge sclk);
        tests++; if (po_data !== 8'h00) begin fails++; $display("FAIL reset_po_data: got %h required 00", po_data); end
        tests++; if (po_flag !== 1'b0) begin fails++; $display("FAIL reset_po_flag: got %b required 0", po_flag); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_rx_busy: got %b required 0", rx_busy); end
        s_rst_n = 1'b1;
        repeat (5) @(negedge sclk);
        clear_log();
    endtask

    task automatic test_single();
        int  n;
        bit  seen;
        clear_log();
        n    = 0;
        seen = 0;
        @(negedge sclk);
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge sclk);
                while (!seen && n < 700) begin
                    @(posedge sclk);
                    n++;
                    #1;
                    if (po_flag) seen = 1;
                end
            end
        join
        repeat (10) @(negedge sclk);
        tests++; if (n !== 543) begin fails++; $display("FAIL single_latency: got %0d edges required 543", n); end
        tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL single_count: got %0d pulses required 1", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== 8'h55) begin fails++; $display("FAIL single_data: got %h required 55", got_q[0]); end
        end
        tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL single_frame_err: got %0d pulses required 0", fe_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[4];
        exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF; exp[3] = 8'h00;
        clear_log();
        @(negedge sclk);
        for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1);
        repeat (20) @(negedge sclk);
        tests++; if (got_q.size() !== 4) begin fails++; $display("FAIL b2b_count: got %0d pulses required 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                tests++; if (got_q[i] !== exp[i]) begin fails++; $display("FAIL b2b_data[%0d]: got %h required %h", i, got_q[i], exp[i]); end
            end
        end
        tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL b2b_frame_err: got %0d pulses required 0", fe_cnt); end
    endtask

    task automatic test_glitch();
        clear_log();
        @(negedge sclk);
        rs232_rx = 1'b0;
        repeat (10) @(negedge sclk);
        rs232_rx = 1'b1;
        tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_high: got %b required 1", rx_busy); end
        repeat (60) @(negedge sclk);
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_low: got %b required 0", rx_busy); end
        tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL glitch_po_flag: got %0d pulses required 0", got_q.size()); end
        tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL glitch_frame_err: got %0d pulses required 0", fe_cnt); end
    endtask

    task automatic test_frame_err();
        clear_log();
        @(negedge sclk);
        send_frame(8'h81, 1'b0);
        repeat (20) @(negedge sclk);
        tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL ferr_count: got %0d pulses required 1", fe_cnt); end
        tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL ferr_po_flag: got %0d pulses required 0", got_q.size()); end
        tests++; if (po_data !== 8'h00) begin fails++; $display("FAIL ferr_po_data: got %h required 00", po_data); end
        tests++; if (both_cnt !== 0) begin fails++; $display("FAIL ferr_overlap: got %0d cycles required 0", both_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        @(negedge sclk);
        send_frame(8'h6B, 1'b1);
        repeat (10) @(negedge sclk);
        tests++; if (po_data !== 8'h6B) begin fails++; $display("FAIL rstmid_pre_data: got %h required 6b", po_data); end
        clear_log();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * BIT_CYC + 20) @(negedge sclk);
                s_rst_n = 1'b0;
                #1;
                tests++; if (po_data !== 8'h00) begin fails++; $display("FAIL rstmid_po_data: got %h required 00", po_data); end
                tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL rstmid_rx_busy: got %b required 0", rx_busy); end
                tests++; if (po_flag !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_pulses: got %b%b required 00", po_flag, frame_err); end
                repeat (3) @(negedge sclk);
                s_rst_n = 1'b1;
            end
        join
        repeat (5) @(negedge sclk);
        send_frame(8'h12, 1'b1);
        repeat (10) @(negedge sclk);
        tests++; if (got_q.size() !== 1) begin fails++; $display("FAIL rstmid_count: got %0d pulses required 1", got_q.size()); end
        else begin
            tests++; if (got_q[0] !== 8'h12) begin fails++; $display("FAIL rstmid_data: got %h required 12", got_q[0]); end
        end
        tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL rstmid_frame_err: got %0d pulses required 0", fe_cnt); end
    endtask

    task automatic test_loopback();
        logic [7:0] exp[$];
        for (int k = 0; k < 16; k++) exp.push_back(8'(k * 17));
        for (int k = 0; k < 8; k++) exp.push_back(8'(1 << k));
        clear_log();
        @(negedge sclk);
        foreach (exp[i]) send_frame(exp[i], 1'b1);
        repeat (20) @(negedge sclk);
        tests++; if (got_q.size() !== exp.size()) begin fails++; $display("FAIL loop_count: got %0d pulses required %0d", got_q.size(), exp.size()); end
        foreach (exp[i]) begin
            if (i < got_q.size()) begin
                tests++; if (got_q[i] !== exp[i]) begin fails++; $display("FAIL loop_data[%0d]: got %h required %h", i, got_q[i], exp[i]); end
            end
        end
        tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL loop_frame_err: got %0d pulses required 0", fe_cnt); end
        tests++; if (both_cnt !== 0) begin fails++; $display("FAIL loop_overlap: got %0d cycles required 0", both_cnt); end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        fe_cnt   = 0;
        both_cnt = 0;
        s_rst_n  = 1'b0;
        rs232_rx = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
